// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the x^49 + x^40 + 1 PRBS checker and generator.
//   - PRBS_LEN, PRBS_TAP_A/B : LFSR length and feedback taps (1-based exponents)
//   - ERR_CNT_W, BIT_CNT_W   : widths of the error and checked-bit counters
//   - prbs_state_e           : checker state (seed, search, locked)
//   - prbs_predict()         : next sequence bit from a history register (bit 0 newest)
package prbs_pkg;

  localparam int unsigned PRBS_LEN   = 49;
  localparam int unsigned PRBS_TAP_A = 49;
  localparam int unsigned PRBS_TAP_B = 40;

  localparam int unsigned ERR_CNT_W = 32;
  localparam int unsigned BIT_CNT_W = 48;

  typedef enum logic [1:0] {
    StSeed,
    StSearch,
    StLocked
  } prbs_state_e;

  // History bit k holds the bit accepted k+1 samples ago, so tap x^n is bit n-1.
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
    return s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1];
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial PRBS stream plus checker status bundle.
//   DATA_IN    : received serial bit            (source -> checker)
//   DATA_VALID : DATA_IN qualifier              (source -> checker)
//   CLEAR_CNT  : synchronous counter clear      (source -> checker)
//   LOCKED     : checker synchronised           (checker -> source)
//   ERROR      : one-cycle pulse per bit error  (checker -> source)
//   ERR_COUNT  : saturating errored-bit count   (checker -> source)
//   BIT_COUNT  : saturating checked-bit count   (checker -> source)
interface prbs_checker_if;
  import prbs_pkg::*;

  logic                 DATA_IN;
  logic                 DATA_VALID;
  logic                 CLEAR_CNT;
  logic                 LOCKED;
  logic                 ERROR;
  logic [ERR_CNT_W-1:0] ERR_COUNT;
  logic [BIT_CNT_W-1:0] BIT_COUNT;

  modport master (
    output DATA_IN,
    output DATA_VALID,
    output CLEAR_CNT,
    input  LOCKED,
    input  ERROR,
    input  ERR_COUNT,
    input  BIT_COUNT
  );

  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    input  CLEAR_CNT,
    output LOCKED,
    output ERROR,
    output ERR_COUNT,
    output BIT_COUNT
  );

endinterface

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: up-counter that sticks at all-ones.
//   CLK     : clock, rising edge
//   RESET_N : asynchronous active-low reset, clears the count
//   inc_i   : count up by one this cycle
//   clear_i : synchronous clear, wins over inc_i
//   count_o : current count
module prbs_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: serial checker for the x^49 + x^40 + 1 PRBS.
//   CLK     : clock, all logic on the rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : prbs_checker_if slave (DATA_IN/DATA_VALID/CLEAR_CNT in,
//             LOCKED/ERROR/ERR_COUNT/BIT_COUNT out)
// Seeds its history from the first PRBS_WIDTH accepted bits, then needs LOCK_COUNT
// consecutive correct predictions to lock. While locked it free-runs on its own
// prediction, flags each differing input bit, and drops back to seeding once
// LOSS_THRESH errors land inside one WINDOW-bit window.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned PRBS_WIDTH  = PRBS_LEN,
  parameter int unsigned LOCK_COUNT  = 64,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned LOSS_THRESH = 16
) (
  input logic           CLK,
  input logic           RESET_N,
  prbs_checker_if.slave bus
);

  localparam int unsigned SeedW  = $clog2(PRBS_WIDTH + 1);
  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WinW   = $clog2(WINDOW + 1);
  localparam int unsigned ErrW   = $clog2(LOSS_THRESH + 1);

  localparam logic [SeedW-1:0]  SeedLast  = SeedW'(PRBS_WIDTH - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW - 1);
  localparam logic [ErrW-1:0]   ErrLast   = ErrW'(LOSS_THRESH - 1);

  prbs_state_e           state_d, state_q;
  logic [PRBS_WIDTH-1:0] s_d, s_q;
  logic [SeedW-1:0]      seed_cnt_d, seed_cnt_q;
  logic [MatchW-1:0]     match_d, match_q;
  logic [WinW-1:0]       win_bits_d, win_bits_q;
  logic [ErrW-1:0]       win_errs_d, win_errs_q;
  logic                  error_d, error_q;
  logic                  locked_d, locked_q;
  logic                  err_inc, bit_inc;
  logic                  predicted, mismatch;

  assign predicted = prbs_predict(s_q);
  assign mismatch  = bus.DATA_IN != predicted;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    seed_cnt_d = seed_cnt_q;
    match_d    = match_q;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    error_d    = 1'b0;
    err_inc    = 1'b0;
    bit_inc    = 1'b0;

    if (bus.DATA_VALID) begin
      case (state_q)
        StSeed: begin
          s_d = {s_q[PRBS_WIDTH-2:0], bus.DATA_IN};
          if (seed_cnt_q == SeedLast) begin
            seed_cnt_d = '0;
            match_d    = '0;
            state_d    = StSearch;
          end else begin
            seed_cnt_d = seed_cnt_q + SeedW'(1);
          end
        end

        StSearch: begin
          s_d = {s_q[PRBS_WIDTH-2:0], bus.DATA_IN};
          if (mismatch) begin
            match_d = '0;
          end else if (match_q == MatchLast) begin
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
            state_d    = StLocked;
          end else begin
            match_d = match_q + MatchW'(1);
          end
        end

        StLocked: begin
          // Free-run on the prediction so a corrupted input bit cannot poison
          // later predictions; each flipped bit then costs exactly one error.
          s_d     = {s_q[PRBS_WIDTH-2:0], predicted};
          bit_inc = 1'b1;
          error_d = mismatch;
          err_inc = mismatch;
          if (mismatch && (win_errs_q == ErrLast)) begin
            seed_cnt_d = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
            state_d    = StSeed;
          end else if (win_bits_q == WinLast) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WinW'(1);
            if (mismatch) begin
              win_errs_d = win_errs_q + ErrW'(1);
            end
          end
        end

        default: state_d = StSeed;
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StSeed;
      s_q        <= '0;
      seed_cnt_q <= '0;
      match_q    <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      seed_cnt_q <= seed_cnt_d;
      match_q    <= match_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      error_q    <= error_d;
      locked_q   <= locked_d;
    end
  end

  prbs_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc_i   (err_inc),
    .clear_i (bus.CLEAR_CNT),
    .count_o (bus.ERR_COUNT)
  );

  prbs_sat_counter #(
    .WIDTH (BIT_CNT_W)
  ) u_bit_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc_i   (bit_inc),
    .clear_i (bus.CLEAR_CNT),
    .count_o (bus.BIT_COUNT)
  );

  assign bus.LOCKED = locked_q;
  assign bus.ERROR  = error_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker. Each driven cycle pushes the
// expected ERROR/LOCKED/ERR_COUNT/BIT_COUNT; the entry is popped and compared one
// cycle later on the falling edge.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int unsigned PW  = 49;
  localparam int unsigned LC  = 64;
  localparam int unsigned WIN = 256;
  localparam int unsigned LT  = 16;
  localparam logic [48:0] SEED = 49'h1_55AA_AA55_55AA;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  prbs_checker_if bus ();

  prbs_checker #(
    .PRBS_WIDTH  (PW),
    .LOCK_COUNT  (LC),
    .WINDOW      (WIN),
    .LOSS_THRESH (LT)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    logic                 err;
    logic                 lock;
    logic [ERR_CNT_W-1:0] errc;
    logic [BIT_CNT_W-1:0] bitc;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic                 m_locked;
  int                   m_since_seed;
  int                   m_wb;
  int                   m_we;
  logic [ERR_CNT_W-1:0] m_errc;
  logic [BIT_CNT_W-1:0] m_bitc;

  // Generator: first emits SEED msb-first, then extends with x^49 + x^40 + 1.
  logic [48:0] g;
  int          g_pre;

  task automatic gen_init();
    g     = SEED;
    g_pre = 49;
  endtask

  task automatic next_bit(output logic b);
    if (g_pre > 0) begin
      b = g[g_pre-1];
      g_pre--;
    end else begin
      b = g[48] ^ g[39];
      g = {g[47:0], b};
    end
  endtask

  task automatic model_reset();
    m_locked     = 1'b0;
    m_since_seed = 0;
    m_wb         = 0;
    m_we         = 0;
    m_errc       = '0;
    m_bitc       = '0;
    sb.delete();
  endtask

  // Drive one cycle at a falling edge, predict, then check at the next falling edge.
  task automatic drive(input logic d, input logic v, input logic clr, input logic flip);
    exp_t e;
    bus.DATA_IN    = d ^ flip;
    bus.DATA_VALID = v;
    bus.CLEAR_CNT  = clr;
    e.err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        m_since_seed++;
        if (m_since_seed == int'(PW + LC)) begin
          m_locked = 1'b1;
          m_wb     = 0;
          m_we     = 0;
        end
      end else begin
        e.err = flip;
        if (m_bitc != '1) m_bitc++;
        if (flip && (m_errc != '1)) m_errc++;
        m_wb++;
        if (flip) m_we++;
        if (m_we == int'(LT)) begin
          m_locked     = 1'b0;
          m_since_seed = 0;
          m_wb         = 0;
          m_we         = 0;
        end else if (m_wb == int'(WIN)) begin
          m_wb = 0;
          m_we = 0;
        end
      end
    end
    if (clr) begin
      m_errc = '0;
      m_bitc = '0;
    end
    e.lock = m_locked;
    e.errc = m_errc;
    e.bitc = m_bitc;
    sb.push_back(e);

    @(negedge CLK);
    e = sb.pop_front();
    checks++;
    if (bus.ERROR !== e.err) begin
      failures++;
      $display("FAIL error_pulse t=%0t: got %b expected %b", $time, bus.ERROR, e.err);
    end
    checks++;
    if (bus.LOCKED !== e.lock) begin
      failures++;
      $display("FAIL locked t=%0t: got %b expected %b", $time, bus.LOCKED, e.lock);
    end
    checks++;
    if (bus.ERR_COUNT !== e.errc) begin
      failures++;
      $display("FAIL err_count t=%0t: got %0h expected %0h", $time, bus.ERR_COUNT, e.errc);
    end
    checks++;
    if (bus.BIT_COUNT !== e.bitc) begin
      failures++;
      $display("FAIL bit_count t=%0t: got %0h expected %0h", $time, bus.BIT_COUNT, e.bitc);
    end
  endtask

  task automatic send(input int n, input int flip_every, input int flip_limit);
    logic b;
    int   flips = 0;
    for (int i = 0; i < n; i++) begin
      logic f;
      next_bit(b);
      f = (flip_every > 0) && (i % flip_every == 0) && (flips < flip_limit);
      if (f) flips++;
      drive(b, 1'b1, 1'b0, f);
    end
  endtask

  task automatic align_window();
    for (int i = 0; i < 300 && m_wb != 0; i++) send(1, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bus.LOCKED, bus.ERROR, bus.ERR_COUNT, bus.BIT_COUNT} !== '0) begin
      failures++;
      $display("FAIL %s: got locked=%b error=%b err=%0h bits=%0h expected all 0", tag,
               bus.LOCKED, bus.ERROR, bus.ERR_COUNT, bus.BIT_COUNT);
    end
  endtask

  task automatic test_reset();
    RESET_N        = 1'b0;
    bus.DATA_IN    = 1'b0;
    bus.DATA_VALID = 1'b0;
    bus.CLEAR_CNT  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset_state");
    RESET_N = 1'b1;
    model_reset();
    gen_init();
  endtask

  task automatic test_lock();
    send(int'(PW + LC) + 20, 0, 0);
  endtask

  task automatic test_single_error();
    logic [ERR_CNT_W-1:0] start;
    start = m_errc;
    send(1, 1, 1);
    send(10, 0, 0);
    checks++;
    if (bus.ERR_COUNT !== start + 32'd1 || bus.LOCKED !== 1'b1) begin
      failures++;
      $display("FAIL single_error: got err=%0h locked=%b expected err=%0h locked=1",
               bus.ERR_COUNT, bus.LOCKED, start + 32'd1);
    end
  endtask

  task automatic test_loss_relock();
    logic [ERR_CNT_W-1:0] start;
    align_window();
    start = m_errc;
    send(61, 4, 16);
    checks++;
    if (bus.ERR_COUNT !== start + 32'd16 || bus.LOCKED !== 1'b0) begin
      failures++;
      $display("FAIL loss_of_lock: got err=%0h locked=%b expected err=%0h locked=0",
               bus.ERR_COUNT, bus.LOCKED, start + 32'd16);
    end
    send(int'(PW + LC) + 5, 0, 0);
  endtask

  task automatic test_two_windows();
    logic [ERR_CNT_W-1:0] start;
    align_window();
    start = m_errc;
    send(int'(WIN), 4, 15);
    send(int'(WIN), 4, 15);
    checks++;
    if (bus.ERR_COUNT !== start + 32'd30 || bus.LOCKED !== 1'b1) begin
      failures++;
      $display("FAIL two_windows: got err=%0h locked=%b expected err=%0h locked=1",
               bus.ERR_COUNT, bus.LOCKED, start + 32'd30);
    end
  endtask

  task automatic test_valid_toggle();
    logic b;
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
    gen_init();
    for (int i = 0; i < int'(PW + LC) + 5; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0, 1'b0);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    send(3, 1, 1);
    next_bit(b);
    drive(b, 1'b1, 1'b1, 1'b1);
    send(3, 0, 0);
    checks++;
    if (bus.ERR_COUNT !== 32'd0) begin
      failures++;
      $display("FAIL clear_with_error: got %0h expected 0", bus.ERR_COUNT);
    end
  endtask

  task automatic test_saturation();
    force dut.u_err_cnt.count_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_err_cnt.count_q;
    m_errc = 32'hFFFF_FFFD;
    send(40, 8, 5);
    checks++;
    if (bus.ERR_COUNT !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL err_saturate: got %0h expected ffffffff", bus.ERR_COUNT);
    end
  endtask

  task automatic test_reset_mid_lock();
    checks++;
    if (bus.LOCKED !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_locked: got %b expected 1", bus.LOCKED);
    end
    bus.DATA_VALID = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
    send(int'(PW + LC) + 5, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_two_windows();
    test_valid_toggle();
    test_saturation();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
